// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multicycle multiply/divide controller for the execute stage.
//
// Accepts one MULT/MULTU/DIV/DIVU operation, stalls the pipeline (busy_o)
// while it runs, then presents a single-cycle pair of HI/LO writes.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous, active-high reset
//   start_i     issue request, sampled only in IDLE or DONE
//   op_i[1:0]   operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   a_i[31:0]   rs operand (dividend / multiplicand)
//   b_i[31:0]   rt operand (divisor / multiplier)
//   flush_i     abort current operation; suppresses a DONE write in the same cycle
//   busy_o      stall request, high in MUL and DIV
//   done_o      one-cycle completion pulse
//   hi_write_o  HI write request {valid, data[31:0]}
//   lo_write_o  LO write request {valid, data[31:0]}
module mdu_ctrl #(
  parameter int MULT_CYCLES = 4  // busy cycles for MULT/MULTU, 1..32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [32:0] hi_write_o,
  output logic [32:0] lo_write_o
);

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [32:0] rem_q;   // partial remainder
  logic [31:0] quo_q;   // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] dvs_q;   // divisor magnitude

  // Operand magnitudes for signed divide, taken at accept time
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  assign a_mag = (op_i == OP_DIV && a_i[31]) ? -a_i : a_i;
  assign b_mag = (op_i == OP_DIV && b_i[31]) ? -b_i : b_i;

  // 64-bit product from latched operands; sign extension makes one
  // truncated 64x64 multiplier serve both signed and unsigned forms.
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  assign mul_signed = (op_q == OP_MULT);
  assign mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
  assign mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
  assign product    = mul_a * mul_b;

  // One restoring-division step: shift in the next dividend bit, try to
  // subtract the divisor, keep the difference only if it did not borrow.
  logic [32:0] rem_shift;
  logic [33:0] rem_diff;
  logic        rem_ge;
  logic [32:0] rem_d;
  logic [31:0] quo_d;
  assign rem_shift = {rem_q[31:0], quo_q[31]};
  assign rem_diff  = {rem_q[32], rem_shift} - {2'b00, dvs_q};
  assign rem_ge    = ~rem_diff[33];
  assign rem_d     = rem_ge ? rem_diff[32:0] : rem_shift;
  assign quo_d     = {quo_q[30:0], rem_ge};

  // Sign fix-up applied to the final step's results; the 0x80000000 / -1
  // case wraps naturally through the negation.
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] lo_fix;
  logic [31:0] hi_fix;
  assign neg_quo = (op_q == OP_DIV) && (a_q[31] ^ b_q[31]);
  assign neg_rem = (op_q == OP_DIV) && a_q[31];
  assign lo_fix  = neg_quo ? -quo_d : quo_d;
  assign hi_fix  = neg_rem ? -rem_d[31:0] : rem_d[31:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
    end else if (flush_i) begin
      // Flush wins over any start presented in the same cycle
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
            if (!op_i[1]) begin
              cnt_q   <= MUL_LOAD;
              state_q <= S_MUL;
            end else if (b_i == 32'd0) begin
              // Divide by zero completes immediately with a fixed result
              hi_q    <= a_i;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= 5'd31;
              rem_q   <= 33'd0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              state_q <= S_DIV;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_MUL: begin
          if (cnt_q == 5'd0) begin
            hi_q    <= product[63:32];
            lo_q    <= product[31:0];
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end

        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == 5'd0) begin
            hi_q    <= hi_fix;
            lo_q    <= lo_fix;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; flush only gates the DONE write.
  logic wr_valid;
  assign wr_valid   = (state_q == S_DONE) && !flush_i;
  assign busy_o     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o     = wr_valid;
  assign hi_write_o = wr_valid ? {1'b1, hi_q} : 33'd0;
  assign lo_write_o = wr_valid ? {1'b1, lo_q} : 33'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  localparam int MC = 4;
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [32:0] hi_write;
  logic [32:0] lo_write;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.MULT_CYCLES(MC)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .flush_i    (flush),
    .busy_o     (busy),
    .done_o     (done),
    .hi_write_o (hi_write),
    .lo_write_o (lo_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation in the current cycle (cycle 0); returns in cycle 1
  // with operands scrambled to show they are not re-sampled.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Starting in cycle 1, advance until done; cyc = cycle of done, nb = busy cycles.
  // With noise set, random start pulses are driven during every busy cycle.
  task automatic wait_done(input bit noise, output int cyc, output int nb);
    cyc = 1;
    nb  = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      if (noise && busy) begin
        start = 1'b1;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
  endtask

  // Issue an op and check latency, busy length and the DONE-cycle writes.
  // Returns while still in the DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat, input int nbusy,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int nb;
    issue(o, x, y);
    wait_done(1'b0, cyc, nb);
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_busycyc"}, 64'(nb), 64'(nbusy));
    check({tag, "_hi"}, {31'd0, hi_write}, {31'd0, 1'b1, ehi});
    check({tag, "_lo"}, {31'd0, lo_write}, {31'd0, 1'b1, elo});
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
  endtask

  // Advance one cycle and confirm the block has gone quiet
  task automatic finish_idle(input string tag);
    tick();
    check({tag, "_idle"}, {29'd0, busy, done, hi_write, 1'b0}, 64'd0);
    check({tag, "_idle_lo"}, {31'd0, lo_write}, 64'd0);
  endtask

  initial begin
    int cyc;
    int nb;
    logic seen;

    reset = 1'b1;
    start = 1'b1;
    flush = 1'b0;
    op    = OP_MULTU;
    a     = 32'h5;
    b     = 32'h6;

    // Reset held two cycles with start asserted
    tick();
    tick();
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_hi", {31'd0, hi_write}, 64'd0);
    check("reset_lo", {31'd0, lo_write}, 64'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("post_reset_busy", {62'd0, busy, done}, 64'd0);

    // Multiplies
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MC + 1, MC, 32'h1, 32'hFFFF_FFFE);
    finish_idle("multu");
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, MC + 1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    finish_idle("mult_neg");
    run_op("mult_negneg", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC + 1, MC, 32'h0, 32'h1);
    finish_idle("mult_negneg");

    // Divides
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    finish_idle("div_neg");
    run_op("divu", OP_DIVU, 32'd7, 32'd2, 33, 32, 32'd1, 32'd3);
    finish_idle("divu");
    run_op("div_negdivisor", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32, 32'd1, 32'hFFFF_FFFD);
    finish_idle("div_negdivisor");
    run_op("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32, 32'd0, 32'h8000_0000);
    finish_idle("div_wrap");

    // Divide by zero completes at cycle 1 without busy
    run_op("divu_zero", OP_DIVU, 32'h1234, 32'd0, 1, 0, 32'h1234, 32'hFFFF_FFFF);
    finish_idle("divu_zero");

    // Flush mid-divide, then a fresh multiply at cycle 12
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_c11", {63'd0, busy}, 64'd0);
    seen = hi_write[32] | lo_write[32] | done;
    tick();
    seen = seen | hi_write[32] | lo_write[32] | done | busy;
    check("flush_nowrite", {63'd0, seen}, 64'd0);
    run_op("after_flush", OP_MULTU, 32'd3, 32'd4, MC + 1, MC, 32'd0, 32'd12);
    finish_idle("after_flush");

    // Flush during a DONE cycle suppresses the write
    issue(OP_DIVU, 32'd5, 32'd0);
    check("flushdone_pre", {63'd0, done}, 64'd1);
    flush = 1'b1;
    #1;
    check("flushdone_done", {63'd0, done}, 64'd0);
    check("flushdone_wr", {30'd0, hi_write[32], lo_write[32], 32'd0}, 64'd0);
    tick();
    flush = 1'b0;
    check("flushdone_next", {62'd0, busy, done}, 64'd0);

    // Start in the same cycle as flush is ignored
    op    = OP_MULTU;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flushstart_busy", {63'd0, busy}, 64'd0);
    tick();
    check("flushstart_quiet", {62'd0, busy, done}, 64'd0);

    // Reset mid-multiply
    issue(OP_MULT, 32'd3, 32'd3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_out", {29'd0, busy, done, hi_write[32], lo_write[32], 1'b0}, 64'd0);
    tick();
    check("midreset_quiet", {62'd0, busy, done}, 64'd0);

    // Back-to-back: DIVU accepted in MULT's DONE cycle, noise starts while busy
    run_op("b2b_mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, MC + 1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    #1;
    check("b2b_mult_still_writes", {31'd0, hi_write}, {31'd0, 1'b1, 32'hFFFF_FFFF});
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check("b2b_divu_busy_c1", {63'd0, busy}, 64'd1);
    wait_done(1'b1, cyc, nb);
    check("b2b_divu_lat", 64'(cyc), 64'd33);
    check("b2b_divu_busycyc", 64'(nb), 64'd32);
    check("b2b_divu_hi", {31'd0, hi_write}, {31'd0, 1'b1, 32'd2});
    check("b2b_divu_lo", {31'd0, lo_write}, {31'd0, 1'b1, 32'd14});
    finish_idle("b2b_divu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multicycle multiply/divide controller for the execute stage. Accepts one `multicycle_t` operation (MULT, MULTU, DIV, DIVU) with two `word_t` operands and sequences it over several cycles. While it runs, it holds `busy` high to stall the pipeline. On completion it issues a single-cycle pair of `hilo_write_req` writes to the HI/LO registers.

## Interface
- `MULT_CYCLES`, default 4: busy cycles for MULT/MULTU; legal range 1..32.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue request; sampled only in IDLE or DONE.
- `op` in 2 (`multicycle_t`): operation, qualified by `start`.
- `a` in 32 (`word_t`): rs operand, i.e. the dividend or multiplicand.
- `b` in 32 (`word_t`): rt operand, i.e. the divisor or multiplier.
- `flush` in 1: abort the current operation, for exception or redirect.
- `busy` out 1: stall request; high in MUL and DIV states.
- `done` out 1: one-cycle completion pulse; high in DONE.
- `hi_write` out 33 (`hilo_write_req`): HI write; valid only in DONE.
- `lo_write` out 33 (`hilo_write_req`): LO write; valid only in DONE.

## Operation
- **States:** IDLE, MUL, DIV, DONE. Reset goes to IDLE and clears all outputs, operand registers, counter and results to 0.
- **Accepting `start`:** when `start=1` and `flush=0` in IDLE or DONE:
  - latch `op`, `a`, `b`;
  - MULT/MULTU: load counter with MULT_CYCLES-1 and go to MUL;
  - DIV/DIVU with `b≠0`: load counter with 31 and go to DIV;
  - DIV/DIVU with `b=0`: go directly to DONE with result HI=`a`, LO=32'hFFFF_FFFF.
- **Outside IDLE/DONE:** `start` is ignored in MUL and DIV.
- **MUL:** the 64-bit product is formed from the latched operands.
  - MULT: signed 32x32 product.
  - MULTU: unsigned product.
  - Result: HI=product[63:32], LO=product[31:0].
  - Counter decrements each cycle; at 0, go to DONE.
- **DIV:** restoring radix-2 division on magnitudes, one quotient bit per cycle, 32 iterations.
  - Partial remainder register is 33 bits.
  - DIV: magnitudes are taken from two's complement.
  - DIVU: operands are used raw.
  - After iteration 31 (counter=0), go to DONE and apply sign fix-up.
- **Sign fix-up (DIV only):**
  - quotient is negated if `a[31]^b[31]`;
  - remainder is negated if `a[31]`.
  - Result: LO=quotient, HI=remainder.
  - Edge case: 32'h8000_0000 / 32'hFFFF_FFFF gives LO=32'h8000_0000, HI=0 (wraps; no trap).
- **DONE:**
  - `hi_write.valid=lo_write.valid=1`, with data equal to the results;
  - `done=1`, `busy=0`.
  - Next state: IDLE, or MUL/DIV/DONE if a new `start` is accepted this cycle.
  - The current write still completes in that cycle.
- **Flush:** `flush=1` in any state gives IDLE next cycle.
  - If in DONE, the writes in that same cycle are suppressed (valid=0, `done=0`).
  - A `start` in the same cycle as `flush` is ignored.
- **Output registers:** `busy` and `done` are decoded from registered state only, so there is no combinational path from `start`.
- **Idle data:** `hi_write.data` and `lo_write.data` are 0 when valid=0.

## Timing
- `start` is accepted at cycle 0; the state changes at the cycle 1 edge.
- MULT/MULTU:
  - `busy=1` for cycles 1..MULT_CYCLES;
  - DONE at cycle MULT_CYCLES+1.
- DIV/DIVU, `b≠0`:
  - `busy=1` for cycles 1..32;
  - DONE at cycle 33.
- DIV/DIVU, `b=0`: DONE at cycle 1, with `busy` never high.
- Back-to-back operation:
  - a `start` in the DONE cycle gives the next op's first busy cycle immediately after;
  - there is no idle bubble.
- Reset mid-operation gives IDLE next cycle, with no write.
- Operand inputs may change after the accept cycle without affecting the result.

## Test plan
- **Reset:** assert `reset` 2 cycles -> `busy=0`, `done=0`, both writes valid=0, data=0; `start` during reset is ignored.
- **MULTU and MULT, MULT_CYCLES=4:**
  - MULTU `a`=32'hFFFF_FFFF, `b`=2 -> `busy` high cycles 1-4; cycle 5 `done=1`, HI=1, LO=32'hFFFF_FFFE.
  - MULT `a`=32'hFFFF_FFFD (-3), `b`=5 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1.
- **DIV and DIVU:**
  - DIV `a`=-7, `b`=2 -> cycle 33: LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
  - DIVU `a`=7, `b`=2 -> LO=3, HI=1.
  - DIV 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
- **Divide by zero:** DIVU `a`=32'h1234, `b`=0 -> `done` at cycle 1, HI=32'h1234, LO=32'hFFFF_FFFF, `busy` never high.
- **Flush:**
  - DIVU started, `flush` at cycle 10 -> `busy=0` from cycle 11; no write ever.
  - New MULTU issued at cycle 12 -> completes normally at cycle 12+MULT_CYCLES+1.
  - `flush` in a DONE cycle -> valid=0 in that cycle.
- **Back-to-back:** MULT completes, and DIVU `start` is issued in its DONE cycle -> MULT writes that cycle; DIVU `busy` from the next cycle; DIVU `done` 33 cycles after its accept. `start` pulses during MUL/DIV are ignored (results unchanged).
